// File: rtl/poker_player_param_if.sv
// Dealer <-> player handshake bundle: request/acknowledge/invalid from the dealer,
// valid/action/bet from the player.
interface poker_player_param_if #(
   parameter int unsigned W = 8
);
   logic         dealer_request_action;
   logic         dealer_acknowledge;
   logic         invalid_move;
   logic         output_valid;
   logic [2:0]   action;
   logic [W-1:0] make_bet;

   // master is the player, slave is the dealer
   modport master (
      input  dealer_request_action, dealer_acknowledge, invalid_move,
      output output_valid, action, make_bet
   );
   modport slave (
      output dealer_request_action, dealer_acknowledge, invalid_move,
      input  output_valid, action, make_bet
   );
endinterface

// File: rtl/poker_player_param.sv
// Parametrised poker bot: scores the hole cards, decides an action/bet and posts it to the dealer.
// Define BOARD_PAIR_EN to add a bonus when a hole rank pairs a revealed board card.
module poker_player_param #(
   parameter int unsigned W          = 8,
   parameter int unsigned NUM_ROUNDS = 4,
   parameter int unsigned BET_UNIT   = 10,
   parameter int unsigned HIGH_RANK  = 10,
   parameter int unsigned PLAY_TH    = 2,
   parameter int unsigned RAISE_TH   = 3,
   parameter int unsigned MAX_RETRY  = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   poker_player_param_if.master    bus,
   input  logic [5:0]              card1,
   input  logic [5:0]              card2,
   input  logic [17:0]             flop,
   input  logic [5:0]              turn,
   input  logic [5:0]              river,
   input  logic [W-1:0]            money_left,
   input  logic [2:0]              action_opponent,
   input  logic [W-1:0]            bet_opponent,
   input  logic [W-1:0]            pot_size,
   input  logic                    next_deal,
   input  logic                    betting_round_done,
   output logic [1:0]              round_idx
);
   localparam int unsigned AW = W + 4;
   localparam int unsigned RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

   localparam logic [2:0] ActNone  = 3'b000;
   localparam logic [2:0] ActFold  = 3'b001;
   localparam logic [2:0] ActCheck = 3'b010;
   localparam logic [2:0] ActAllIn = 3'b011;
   localparam logic [2:0] ActCall  = 3'b100;
   localparam logic [2:0] ActBet   = 3'b110;
   localparam logic [2:0] ActRaise = 3'b111;

   localparam logic [3:0]    HighRank  = 4'(HIGH_RANK);
   localparam logic [2:0]    PlayTh    = 3'(PLAY_TH);
   localparam logic [2:0]    RaiseTh   = 3'(RAISE_TH);
   localparam logic [RW-1:0] MaxRetry  = RW'(MAX_RETRY);
   localparam logic [1:0]    LastRound = 2'(NUM_ROUNDS - 1);
   localparam logic [AW-1:0] BetUnit   = AW'(BET_UNIT);

   typedef enum logic [2:0] {
      StIdle, StDecide, StSend, StPosted, StDowngrade, StDone
   } state_e;

   state_e        state_q, state_d;
   logic [1:0]    round_q, round_d;
   logic [RW-1:0] retry_q, retry_d;
   logic [2:0]    action_q, action_d;
   logic [W-1:0]  bet_q, bet_d;
   logic          valid_q, valid_d;

   logic [3:0]    rank1, rank2;
   logic [2:0]    score;
   logic [AW-1:0] amount;
   logic [2:0]    dec_action, dg_action;
   logic [W-1:0]  dec_bet;

   // Board and pot inputs are unused in the default build
   logic unused_inputs;
   assign unused_inputs = ^{pot_size, flop, turn, river};

   assign rank1 = card1[3:0];
   assign rank2 = card2[3:0];

   always_comb begin
      score = 3'd0;
      if (rank1 == rank2) score = score + 3'd2;
      if (rank1 > HighRank && rank2 > HighRank) score = score + 3'd1;
      if (card1[5:4] == card2[5:4]) score = score + 3'd1;
`ifdef BOARD_PAIR_EN
      begin
         logic board_hit;
         board_hit = 1'b0;
         if (round_q >= 2'd1) begin
            for (int i = 0; i < 3; i++) begin
               if (flop[6*i +: 4] == rank1 || flop[6*i +: 4] == rank2) board_hit = 1'b1;
            end
         end
         if (round_q >= 2'd2 && (turn[3:0] == rank1 || turn[3:0] == rank2)) board_hit = 1'b1;
         if (round_q >= 2'd3 && (river[3:0] == rank1 || river[3:0] == rank2)) board_hit = 1'b1;
         if (board_hit) score = (score > 3'd5) ? 3'd7 : score + 3'd2;
      end
`endif
   end

   always_comb begin
      dec_action = ActCheck;
      amount     = '0;
      dec_bet    = '0;
      case (action_opponent)
         ActFold: dec_action = ActCheck;
         ActNone, ActCheck, ActCall: begin
            if (score >= PlayTh) begin
               dec_action = ActBet;
               amount     = BetUnit << round_q;
            end
         end
         ActBet, ActRaise: begin
            if (score >= RaiseTh) begin
               dec_action = ActRaise;
               amount     = AW'(bet_opponent) + BetUnit;
            end else if (score >= PlayTh) begin
               dec_action = ActCall;
            end else begin
               dec_action = ActFold;
            end
         end
         ActAllIn: dec_action = (score >= PlayTh) ? ActCall : ActFold;
         default:  dec_action = ActCheck;
      endcase
      // Empty stack cannot back a wager; otherwise a bet covering the stack goes all-in
      if (dec_action == ActBet || dec_action == ActRaise) begin
         if (money_left == '0) begin
            dec_action = (action_opponent == ActCheck) ? ActCheck : ActFold;
         end else if (amount >= AW'(money_left)) begin
            dec_action = ActAllIn;
            dec_bet    = money_left;
         end else begin
            dec_bet = W'(amount);
         end
      end
   end

   always_comb begin
      dg_action = ActFold;
      if (retry_q < MaxRetry) begin
         case (action_q)
            ActRaise: dg_action = ActCall;
            ActBet:   dg_action = ActCheck;
            default:  dg_action = ActFold;
         endcase
      end
   end

   always_comb begin
      state_d  = state_q;
      round_d  = round_q;
      retry_d  = retry_q;
      action_d = action_q;
      bet_d    = bet_q;
      valid_d  = 1'b0;
      if (next_deal) begin
         state_d  = StIdle;
         round_d  = '0;
         retry_d  = '0;
         action_d = ActNone;
         bet_d    = '0;
      end else begin
         case (state_q)
            StIdle: if (bus.dealer_request_action) state_d = StDecide;
            StDecide: begin
               action_d = dec_action;
               bet_d    = dec_bet;
               retry_d  = '0;
               state_d  = StSend;
            end
            StSend: begin
               if (valid_q && bus.dealer_acknowledge) state_d = StPosted;
               else valid_d = 1'b1;
            end
            StPosted: begin
               if (bus.invalid_move) begin
                  state_d = StDowngrade;
               end else if (bus.dealer_request_action) begin
                  state_d = StDecide;
               end else if (betting_round_done) begin
                  if (round_q == LastRound) begin
                     state_d = StDone;
                  end else begin
                     round_d = round_q + 2'd1;
                     state_d = StIdle;
                  end
               end
            end
            StDowngrade: begin
               action_d = dg_action;
               bet_d    = '0;
               retry_d  = (retry_q == MaxRetry) ? retry_q : retry_q + RW'(1);
               state_d  = StSend;
            end
            StDone:  state_d = StDone;
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         round_q  <= '0;
         retry_q  <= '0;
         action_q <= ActNone;
         bet_q    <= '0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         round_q  <= round_d;
         retry_q  <= retry_d;
         action_q <= action_d;
         bet_q    <= bet_d;
         valid_q  <= valid_d;
      end
   end

   assign bus.output_valid = valid_q;
   assign bus.action       = action_q;
   assign bus.make_bet     = bet_q;
   assign round_idx        = round_q;
endmodule

// File: tb/tb_poker_player_param.sv
// Directed bench for poker_player_param: decisions, clamping, downgrade, rounds and reset paths.
module tb_poker_player_param;
   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic [5:0]   card1, card2, turn, river;
   logic [17:0]  flop;
   logic [W-1:0] money_left, bet_opponent, pot_size;
   logic [2:0]   action_opponent;
   logic         next_deal, betting_round_done;
   logic [1:0]   round_idx;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   poker_player_param_if #(.W(W)) bus ();

   poker_player_param #(.W(W)) dut (
      .clk               (clk),
      .rst               (rst),
      .bus               (bus),
      .card1             (card1),
      .card2             (card2),
      .flop              (flop),
      .turn              (turn),
      .river             (river),
      .money_left        (money_left),
      .action_opponent   (action_opponent),
      .bet_opponent      (bet_opponent),
      .pot_size          (pot_size),
      .next_deal         (next_deal),
      .betting_round_done(betting_round_done),
      .round_idx         (round_idx)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic request(input string tag, input logic [2:0] exp_act, input logic [31:0] exp_bet);
      bus.dealer_request_action = 1'b1;
      tick();
      bus.dealer_request_action = 1'b0;
      tick();
      tick();
      check({tag, " valid"}, {31'd0, bus.output_valid}, 32'd1);
      check({tag, " action"}, {29'd0, bus.action}, {29'd0, exp_act});
      check({tag, " bet"}, {24'd0, bus.make_bet}, exp_bet);
   endtask

   task automatic ack(input string tag);
      bus.dealer_acknowledge = 1'b1;
      tick();
      bus.dealer_acknowledge = 1'b0;
      check({tag, " drop"}, {31'd0, bus.output_valid}, 32'd0);
   endtask

   task automatic reject(input string tag, input logic [2:0] exp_act);
      bus.invalid_move = 1'b1;
      tick();
      bus.invalid_move = 1'b0;
      tick();
      tick();
      check({tag, " valid"}, {31'd0, bus.output_valid}, 32'd1);
      check({tag, " action"}, {29'd0, bus.action}, {29'd0, exp_act});
      check({tag, " bet"}, {24'd0, bus.make_bet}, 32'd0);
      ack(tag);
   endtask

   task automatic round_done();
      betting_round_done = 1'b1;
      tick();
      betting_round_done = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      card1 = 6'h0C; card2 = 6'h1C;  // pair of 12s, offsuit
      flop = '0; turn = '0; river = '0;
      money_left = 8'd100; bet_opponent = '0; pot_size = '0;
      action_opponent = 3'b010;
      next_deal = 1'b0; betting_round_done = 1'b0;
      bus.dealer_request_action = 1'b0;
      bus.dealer_acknowledge = 1'b0;
      bus.invalid_move = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      tick();
      check("rst valid", {31'd0, bus.output_valid}, 32'd0);
      check("rst action", {29'd0, bus.action}, 32'd0);
      check("rst bet", {24'd0, bus.make_bet}, 32'd0);
      check("rst round", {30'd0, round_idx}, 32'd0);

      // Latency and hold: valid only after the second edge past the request
      bus.dealer_request_action = 1'b1;
      tick();
      bus.dealer_request_action = 1'b0;
      check("lat n", {31'd0, bus.output_valid}, 32'd0);
      tick();
      check("lat n+1", {31'd0, bus.output_valid}, 32'd0);
      tick();
      check("lat n+2", {31'd0, bus.output_valid}, 32'd1);
      check("bet action", {29'd0, bus.action}, 32'd6);
      check("bet amount", {24'd0, bus.make_bet}, 32'd10);
      tick();
      tick();
      check("hold valid", {31'd0, bus.output_valid}, 32'd1);
      check("hold action", {29'd0, bus.action}, 32'd6);
      check("hold bet", {24'd0, bus.make_bet}, 32'd10);
      ack("bet");

      action_opponent = 3'b110; bet_opponent = 8'd20;
      request("raise", 3'b111, 32'd30);
      ack("raise");
      reject("dg1", 3'b100);
      reject("dg2", 3'b001);
      reject("dg3", 3'b001);

      action_opponent = 3'b010; bet_opponent = '0; money_left = 8'd5;
      request("allin", 3'b011, 32'd5);
      ack("allin");

      action_opponent = 3'b110; bet_opponent = 8'd20; money_left = 8'd0;
      request("broke", 3'b001, 32'd0);
      ack("broke");

      action_opponent = 3'b011; money_left = 8'd100;
      request("vs allin", 3'b100, 32'd0);
      ack("vs allin");

      card1 = 6'h03; card2 = 6'h17;  // 3 and 7 offsuit
      action_opponent = 3'b111;
      request("weak fold", 3'b001, 32'd0);
      ack("weak fold");
      action_opponent = 3'b010;
      request("weak check", 3'b010, 32'd0);
      ack("weak check");

      // Walk the rounds with the strong hand; the bet doubles each round
      card1 = 6'h0C; card2 = 6'h1C;
      round_done();
      check("round 1", {30'd0, round_idx}, 32'd1);
      request("r1", 3'b110, 32'd20);
      ack("r1");
      round_done();
      check("round 2", {30'd0, round_idx}, 32'd2);
      request("r2", 3'b110, 32'd40);
      ack("r2");
      round_done();
      check("round 3", {30'd0, round_idx}, 32'd3);
      request("r3", 3'b110, 32'd80);
      ack("r3");
      round_done();
      check("done round", {30'd0, round_idx}, 32'd3);
      bus.dealer_request_action = 1'b1;
      tick();
      bus.dealer_request_action = 1'b0;
      tick();
      tick();
      tick();
      check("done ignores req", {31'd0, bus.output_valid}, 32'd0);

      next_deal = 1'b1;
      tick();
      next_deal = 1'b0;
      check("deal round", {30'd0, round_idx}, 32'd0);
      request("after deal", 3'b110, 32'd10);
      next_deal = 1'b1;
      tick();
      next_deal = 1'b0;
      check("deal in send", {31'd0, bus.output_valid}, 32'd0);

      request("pre rst", 3'b110, 32'd10);
      #2;
      rst = 1'b1;
      #1;
      check("async rst valid", {31'd0, bus.output_valid}, 32'd0);
      check("async rst action", {29'd0, bus.action}, 32'd0);
      rst = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/poker_player_param.md
Name: poker_player_param

Overview:
- Parametrised next-generation poker bot. Plugs into the dealer in place of the fixed-strategy players and has the dealer handshake built in.
- Scores the hole cards, then picks an action and bet from that score, the opponent's last action and the betting round.
- Bet sizes, thresholds, round count and data width are generics.
- New over the previous generation:
  - bet scaling per round, clamped to the stack;
  - automatic ALL_IN when the bet covers the stack;
  - action downgrade when the dealer flags an invalid move, with a retry limit.

Parameters:
- W, 8: width of money, bet and pot values.
- NUM_ROUNDS, 4: betting rounds per hand.
- BET_UNIT, 10: base bet; round r bets BET_UNIT<<r.
- HIGH_RANK, 10: a rank above this counts as high.
- PLAY_TH, 2: minimum strength score needed to enter or continue a pot.
- RAISE_TH, 3: minimum strength score needed to raise.
- MAX_RETRY, 3: invalid moves tolerated per decision before the bot forces FOLD.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- dealer_request_action  in  1  dealer asks for an action
- dealer_acknowledge  in  1  dealer has taken action/make_bet
- output_valid  out  1  action/make_bet are valid
- action  out  3  NO_ACTION=000, FOLD=001, CHECK=010, ALL_IN=011, CALL=100, BET=110, RAISE=111
- make_bet  out  W  bet amount
- card1, card2  in  6  each card: [3:0] rank (2..14), [5:4] suit
- flop  in  18  three flop cards
- turn, river  in  6  board cards
- invalid_move  in  1  dealer rejected the last action
- money_left  in  W  own stack
- action_opponent  in  3  opponent's last action
- bet_opponent  in  W  opponent's last bet
- pot_size  in  W  current pot (unused unless noted)
- next_deal  in  1  new hand started
- betting_round_done  in  1  current round closed
- round_idx  out  2  current betting round, 0..NUM_ROUNDS-1

Behaviour:
- Reset values: output_valid=0, action=NO_ACTION, make_bet=0, round_idx=0, retry count=0, state=IDLE.
- States:
  - IDLE: waits for a request.
  - DECIDE: one cycle; registers the decision.
  - SEND: output_valid=1; action/make_bet held stable until dealer_acknowledge.
  - POSTED: decision accepted; waits for the next event.
  - DOWNGRADE: one cycle; applies the invalid-move downgrade.
  - DONE: all rounds played; waits for next_deal.
- Transitions:
  - IDLE -> DECIDE on request.
  - DECIDE -> SEND.
  - SEND -> POSTED on dealer_acknowledge. output_valid drops in the cycle after the acknowledge.
  - POSTED:
    - invalid_move -> DOWNGRADE;
    - request -> DECIDE;
    - betting_round_done -> IDLE with round_idx+1, or -> DONE when round_idx == NUM_ROUNDS-1.
  - DOWNGRADE -> SEND.
- Priority:
  - next_deal beats every other input in every state: go to IDLE, round_idx=0, retry=0, output_valid=0.
  - In POSTED: invalid_move > request > betting_round_done.
- Latency: request sampled at edge N -> output_valid high after edge N+2.
- Strength score (3-bit):
  - +2 if the two ranks are equal;
  - +1 if both ranks > HIGH_RANK;
  - +1 if suited.
- Decision (s = score):
  - Opponent FOLD -> CHECK.
  - Opponent NO_ACTION, CHECK or CALL: if s>=PLAY_TH, BET with amount BET_UNIT<<round_idx; otherwise CHECK.
  - Opponent BET or RAISE:
    - s>=RAISE_TH -> RAISE with amount bet_opponent+BET_UNIT;
    - else s>=PLAY_TH -> CALL;
    - else FOLD.
  - Opponent ALL_IN -> CALL if s>=PLAY_TH, else FOLD.
  - make_bet = 0 for every action other than BET/RAISE/ALL_IN.
- Amounts: computed at W+4 bits. If amount >= money_left, the action becomes ALL_IN with make_bet=money_left.
- Downgrade on invalid_move:
  - RAISE -> CALL; BET -> CHECK; CALL, CHECK, ALL_IN -> FOLD; FOLD stays FOLD.
  - Each downgrade increments retry.
  - Once retry == MAX_RETRY, the next downgrade forces FOLD.
  - Retry clears on DECIDE.
- money_left == 0 with a BET/RAISE decision -> CHECK if the opponent checked, otherwise FOLD.
- Reset mid-SEND drops output_valid immediately (asynchronous).

Optional Feature:
- Macro: BOARD_PAIR_EN.
- Defined: in round_idx >= 1, add +2 to the score if either hole rank matches any revealed board rank. Revealed means the flop from round 1, the turn from round 2, the river from round 3. The score saturates at 7.
- Undefined: the score uses hole cards only; board inputs are ignored.

Test Plan:
- card1=rank 12 suit 0, card2=rank 12 suit 1; opponent CHECK; request in round 0 -> output_valid high after 2 cycles, BET, make_bet=10, held until acknowledge.
- Same hand; opponent BET, bet_opponent=20, money_left=100 -> RAISE, make_bet=30.
- Same hand; opponent CHECK, money_left=5 -> ALL_IN, make_bet=5.
- Hand 3 and 7 offsuit; opponent RAISE -> FOLD. Same hand with opponent CHECK -> CHECK, make_bet=0.
- RAISE issued, then invalid_move asserted three times -> sequence CALL, FOLD, FOLD; output_valid re-asserted after each invalid_move.
- Four betting_round_done pulses -> round_idx steps 0..3, state DONE, requests ignored; next_deal -> round_idx=0, IDLE. next_deal asserted during SEND -> output_valid low in the next cycle.
